// File: rtl/faddsub_pipe.sv
// Three-stage pipelined floating-point add/sub (align, add, normalise) with truncation and flush-to-zero.
// Latency 3 cycles; stall propagates from out_ready, and the whole pipe holds while the output is full and unaccepted.
module faddsub_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_sub,
  input  logic [EXP_W+MAN_W:0]   adata,
  input  logic [EXP_W+MAN_W:0]   bdata,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   result,
  output logic [TAG_W-1:0]       out_tag
);

  localparam int W = 1 + EXP_W + MAN_W;
  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef struct packed {
    logic             sgn;
    logic             eff_sub;
    logic [EXP_W-1:0] exp;
    logic [MAN_W:0]   big_sig;
    logic [MAN_W:0]   sml_sig;
    logic             byp;
    logic [W-1:0]     byp_val;
    logic [TAG_W-1:0] tag;
  } align_t;

  typedef struct packed {
    logic             sgn;
    logic [EXP_W-1:0] exp;
    logic [MAN_W+1:0] sum;
    logic             byp;
    logic [W-1:0]     byp_val;
    logic [TAG_W-1:0] tag;
  } add_t;

  logic             v1, v2, v3;
  logic             adv;
  align_t           s1, s1_d;
  add_t             s2, s2_d;
  logic [W-1:0]     res_q, res_d;
  logic [TAG_W-1:0] tag_q;

  // Operand decode; b is taken with its effective sign
  logic             a_s, b_s;
  logic [EXP_W-1:0] a_e, b_e, diff;
  logic [MAN_W-1:0] a_m, b_m;
  logic [W-1:0]     eb;
  logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_ge;

  assign a_s    = adata[W-1];
  assign a_e    = adata[W-2:MAN_W];
  assign a_m    = adata[MAN_W-1:0];
  assign b_s    = bdata[W-1] ^ in_sub;
  assign b_e    = bdata[W-2:MAN_W];
  assign b_m    = bdata[MAN_W-1:0];
  assign eb     = {b_s, b_e, b_m};
  assign a_zero = (a_e == '0);
  assign b_zero = (b_e == '0);
  assign a_inf  = (a_e == EXP_ONES) && (a_m == '0);
  assign b_inf  = (b_e == EXP_ONES) && (b_m == '0);
  assign a_nan  = (a_e == EXP_ONES) && (a_m != '0);
  assign b_nan  = (b_e == EXP_ONES) && (b_m != '0);
  assign a_ge   = ({a_e, a_m} >= {b_e, b_m});

  assign adv       = !v3 || out_ready;
  assign in_ready  = adv;
  assign out_valid = v3;
  assign result    = res_q;
  assign out_tag   = tag_q;

  // Stage 1: order operands by magnitude and align the smaller significand
  always_comb begin
    s1_d         = '0;
    diff         = '0;
    s1_d.tag     = in_tag;
    s1_d.eff_sub = a_s ^ b_s;
    if (a_ge) begin
      s1_d.sgn     = a_s;
      s1_d.exp     = a_e;
      s1_d.big_sig = {1'b1, a_m};
      diff         = a_e - b_e;
      s1_d.sml_sig = {1'b1, b_m} >> diff;
    end else begin
      s1_d.sgn     = b_s;
      s1_d.exp     = b_e;
      s1_d.big_sig = {1'b1, b_m};
      diff         = b_e - a_e;
      s1_d.sml_sig = {1'b1, a_m} >> diff;
    end

    // Specials outrank zeros so a NaN is always canonicalised
    s1_d.byp = 1'b1;
    if (a_nan || b_nan || (a_inf && b_inf && s1_d.eff_sub)) s1_d.byp_val = QNAN;
    else if (a_inf)               s1_d.byp_val = adata;
    else if (b_inf)               s1_d.byp_val = eb;
    else if (a_zero && b_zero)    s1_d.byp_val = '0;
    else if (a_zero)              s1_d.byp_val = eb;
    else if (b_zero)              s1_d.byp_val = adata;
    else                          s1_d.byp     = 1'b0;
  end

  // Stage 2: magnitude add or subtract; big_sig >= sml_sig by construction
  always_comb begin
    s2_d         = '0;
    s2_d.sgn     = s1.sgn;
    s2_d.exp     = s1.exp;
    s2_d.byp     = s1.byp;
    s2_d.byp_val = s1.byp_val;
    s2_d.tag     = s1.tag;
    if (s1.eff_sub) s2_d.sum = {1'b0, s1.big_sig} - {1'b0, s1.sml_sig};
    else            s2_d.sum = {1'b0, s1.big_sig} + {1'b0, s1.sml_sig};
  end

  // Stage 3: normalise, detect overflow to infinity, flush underflow to +0
  int               lz;
  logic [MAN_W-1:0] norm;
  logic [EXP_W-1:0] exp_inc;

  always_comb begin
    res_d   = '0;
    lz      = MAN_W + 1;
    for (int i = 0; i <= MAN_W; i++) begin
      if (s2.sum[i]) lz = MAN_W - i;
    end
    norm    = MAN_W'(s2.sum[MAN_W:0] << lz);
    exp_inc = s2.exp + EXP_W'(1);
    if (s2.byp) begin
      res_d = s2.byp_val;
    end else if (s2.sum[MAN_W+1]) begin
      if (exp_inc == EXP_ONES) res_d = {s2.sgn, EXP_ONES, {MAN_W{1'b0}}};
      else                     res_d = {s2.sgn, exp_inc, s2.sum[MAN_W:1]};
    end else if ((s2.sum == '0) || (int'(s2.exp) <= lz)) begin
      res_d = '0;
    end else begin
      res_d = {s2.sgn, EXP_W'(int'(s2.exp) - lz), norm};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1    <= 1'b0;
      v2    <= 1'b0;
      v3    <= 1'b0;
      s1    <= '0;
      s2    <= '0;
      res_q <= '0;
      tag_q <= '0;
    end else if (adv) begin
      v1    <= in_valid && in_ready;
      v2    <= v1;
      v3    <= v2;
      s1    <= s1_d;
      s2    <= s2_d;
      res_q <= res_d;
      tag_q <= s2.tag;
    end
  end

endmodule
